// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin REQ/GNT with unused-grant revoke.
// GNT, owner and bus-idle status are all registered.
module pci_bus_arbiter #(
   parameter int N_MASTERS   = 4,
   parameter int GNT_TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_MASTERS-1:0]         REQ,
   input  logic                         GLOBAL_FRAME,
   input  logic                         GLOBAL_IRDY,
   output logic [N_MASTERS-1:0]         GNT,
   output logic [$clog2(N_MASTERS)-1:0] owner_id,
   output logic                         owner_valid,
   output logic                         bus_idle
);

   localparam int IDW = $clog2(N_MASTERS);
   localparam int CW  = $clog2(GNT_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(GNT_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ARB_IDLE,
      GRANTED,
      BUSY,
      HANDOVER
   } state_t;

   state_t         state;
   logic [IDW-1:0] rr_last;
   logic [CW-1:0]  cnt;
   logic           idle;
   logic           pick_ok;
   logic [IDW-1:0] pick_idx;
   logic [IDW-1:0] cand;

   assign idle = GLOBAL_FRAME & GLOBAL_IRDY;

   // Walk offsets high to low so the nearest requester after rr_last wins.
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         cand = IDW'((int'(rr_last) + 1 + i) % N_MASTERS);
         if (!REQ[cand]) begin
            pick_ok  = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ARB_IDLE;
         GNT         <= '1;
         owner_id    <= '0;
         owner_valid <= 1'b0;
         bus_idle    <= 1'b1;
         rr_last     <= IDW'(N_MASTERS - 1);
         cnt         <= '0;
      end else begin
         bus_idle <= idle;
         unique case (state)
            ARB_IDLE: begin
               GNT <= '1;
               if (!GLOBAL_FRAME) begin
                  owner_valid <= 1'b1;
                  state       <= BUSY;
               end else if (pick_ok) begin
                  GNT[pick_idx] <= 1'b0;
                  owner_id      <= pick_idx;
                  rr_last       <= pick_idx;
                  owner_valid   <= 1'b1;
                  cnt           <= '0;
                  state         <= GRANTED;
               end
            end
            GRANTED: begin
               if (!GLOBAL_FRAME) begin
                  GNT   <= '1;
                  state <= BUSY;
               end else if (REQ[owner_id]) begin
                  GNT         <= '1;
                  owner_valid <= 1'b0;
                  state       <= ARB_IDLE;
               end else if (cnt == CNT_LAST) begin
                  GNT         <= '1;
                  owner_valid <= 1'b0;
                  state       <= HANDOVER;
               end else if (cnt != '1) begin
                  cnt <= cnt + CW'(1);
               end
            end
            BUSY: begin
               GNT         <= '1;
               owner_valid <= 1'b1;
               if (idle) begin
                  owner_valid <= 1'b0;
                  state       <= ARB_IDLE;
               end
            end
            HANDOVER: begin
               GNT   <= '1;
               state <= ARB_IDLE;
            end
            default: begin
               GNT   <= '1;
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter.
// Steps drive inputs #1 after posedge and check outputs there.
module tb_pci_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'hF;
   logic       frame = 1'b1;
   logic       irdy = 1'b1;
   logic [3:0] gnt;
   logic [1:0] owner_id;
   logic       owner_valid;
   logic       bus_idle;

   int tests = 0;
   int failed = 0;
   logic mon_en = 1'b0;
   logic [3:0] prev_gnt = 4'hF;

   pci_bus_arbiter #(
      .N_MASTERS  (4),
      .GNT_TIMEOUT(16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .REQ         (req),
      .GLOBAL_FRAME(frame),
      .GLOBAL_IRDY (irdy),
      .GNT         (gnt),
      .owner_id    (owner_id),
      .owner_valid (owner_valid),
      .bus_idle    (bus_idle)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // GNT invariants, sampled on the falling edge.
   always @(negedge clk) begin
      logic onehot_ok;
      logic gap_ok;
      if (mon_en) begin
         onehot_ok = ($countones(~gnt) <= 1);
         gap_ok = !(prev_gnt != 4'hF && gnt != 4'hF && gnt != prev_gnt);
         tests++;
         assert (onehot_ok === 1'b1) else begin
            failed++;
            $error("FAIL onehot: observed %b expected at most one low", gnt);
         end
         tests++;
         assert (gap_ok === 1'b1) else begin
            failed++;
            $error("FAIL gap: observed %b after %b expected 1111 between",
                   gnt, prev_gnt);
         end
         prev_gnt = gnt;
      end
   end

   initial begin
      int order [5];
      logic [3:0] eg;
      int lowc;
      order = '{0, 1, 2, 3, 0};

      // Reset held with all requests asserted
      rst_n = 1'b0;
      req = 4'b0000;
      step(); step(); step();
      mon_en = 1'b1;
      check("rst_gnt", gnt, 4'b1111);
      check("rst_ov", owner_valid, 0);
      check("rst_oid", owner_id, 0);
      check("rst_idle", bus_idle, 1);
      rst_n = 1'b1;
      step();
      check("first_gnt", gnt, 4'b1110);
      check("first_ov", owner_valid, 1);
      req = 4'b1111;
      step();
      check("drop_gnt", gnt, 4'b1111);
      check("drop_ov", owner_valid, 0);

      // Single master 2
      req = 4'b1011;
      step();
      check("m2_gnt", gnt, 4'b1011);
      check("m2_oid", owner_id, 2);
      step();
      check("m2_hold", gnt, 4'b1011);
      frame = 1'b0;
      irdy = 1'b0;
      step();
      check("m2_busy_gnt", gnt, 4'b1111);
      check("m2_busy_ov", owner_valid, 1);
      check("m2_busy_idle", bus_idle, 0);
      req = 4'b1111;
      step();
      check("m2_busy2_ov", owner_valid, 1);
      frame = 1'b1;
      irdy = 1'b1;
      step();
      check("m2_end_ov", owner_valid, 0);
      check("m2_end_idle", bus_idle, 1);

      // Round robin from a fresh reset
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         step();
         eg = 4'b1111;
         eg[order[k]] = 1'b0;
         check("rr_gnt", gnt, eg);
         check("rr_oid", owner_id, order[k]);
         frame = 1'b0;
         irdy = 1'b0;
         step();
         check("rr_dead", gnt, 4'b1111);
         step();
         step();
         frame = 1'b1;
         irdy = 1'b1;
         step();
         check("rr_idle_gnt", gnt, 4'b1111);
         check("rr_idle_ov", owner_valid, 0);
      end

      // Timeout: master 1 never starts; master 2 also waiting
      req = 4'b1001;
      step();
      check("to_gnt", gnt, 4'b1101);
      lowc = 1;
      for (int i = 0; i < 15; i++) begin
         step();
         if (gnt == 4'b1101) lowc++;
      end
      check("to_low_cycles", lowc, 16);
      step();
      check("to_revoke_gnt", gnt, 4'b1111);
      check("to_revoke_ov", owner_valid, 0);
      step();
      check("to_handover", gnt, 4'b1111);
      step();
      check("to_next_gnt", gnt, 4'b1011);
      check("to_next_oid", owner_id, 2);
      req = 4'b1111;
      step();
      check("to_release", gnt, 4'b1111);

      // REQ rises on the edge FRAME falls
      req = 4'b1110;
      step();
      check("e1_gnt", gnt, 4'b1110);
      req = 4'b1111;
      frame = 1'b0;
      irdy = 1'b0;
      step();
      check("e1_busy_gnt", gnt, 4'b1111);
      check("e1_busy_ov", owner_valid, 1);
      frame = 1'b1;
      irdy = 1'b1;
      step();
      check("e1_end_ov", owner_valid, 0);

      // Ungranted traffic blocks arbitration
      req = 4'b0111;
      frame = 1'b0;
      irdy = 1'b0;
      step();
      check("e2_busy_gnt", gnt, 4'b1111);
      check("e2_busy_ov", owner_valid, 1);
      check("e2_busy_oid", owner_id, 0);
      step();
      check("e2_busy2_gnt", gnt, 4'b1111);
      frame = 1'b1;
      irdy = 1'b1;
      step();
      check("e2_idle_gnt", gnt, 4'b1111);
      check("e2_idle_ov", owner_valid, 0);
      step();
      check("e2_gnt", gnt, 4'b0111);
      check("e2_oid", owner_id, 3);
      req = 4'b1111;
      step();

      // Reset during BUSY, then during GRANTED
      req = 4'b1011;
      step();
      check("r6_gnt", gnt, 4'b1011);
      frame = 1'b0;
      irdy = 1'b0;
      step();
      check("r6_busy_ov", owner_valid, 1);
      rst_n = 1'b0;
      step();
      check("r6_rst_gnt", gnt, 4'b1111);
      check("r6_rst_ov", owner_valid, 0);
      check("r6_rst_oid", owner_id, 0);
      check("r6_rst_idle", bus_idle, 1);
      rst_n = 1'b1;
      frame = 1'b1;
      irdy = 1'b1;
      req = 4'b1110;
      step();
      check("r6_g_gnt", gnt, 4'b1110);
      rst_n = 1'b0;
      step();
      check("r6_g_rst_gnt", gnt, 4'b1111);
      check("r6_g_rst_ov", owner_valid, 0);
      rst_n = 1'b1;
      req = 4'b1111;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
